// File: rtl/cic_readout_sequencer.sv
// cic_readout_sequencer
// Sequences the CIC decimation datapath and its readout:
//   - programmable decimation strobe (drives the CIC dec_clk input)
//   - capture of each CIC output word into a small FIFO, with priming discard
//   - MSB-byte-first serializer on an 8-bit valid/ready byte port
// Build option: define RDSEQ_CHKSUM_EN to append an XOR checksum byte (state CK)
// after the data bytes of every word; byte_last then qualifies the checksum byte.
module cic_readout_sequencer #(
    parameter int DATA_W  = 24,
    parameter int DEPTH   = 4,
    parameter int DIV_W   = 8,
    parameter int CAP_DLY = 1,
    parameter int PRIME_N = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [DIV_W-1:0]        dec_ratio,
    output logic                    dec_strobe,
    input  logic [DATA_W-1:0]       sample_in,
    output logic [7:0]              byte_out,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    byte_first,
    output logic                    byte_last,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    input  logic                    clr_ovf
);

    // ------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------
    localparam int N_BYTES = DATA_W / 8;
`ifdef RDSEQ_CHKSUM_EN
    localparam int N_STATES = N_BYTES + 2;  // IDLE, B0..B(N-1), CK
`else
    localparam int N_STATES = N_BYTES + 1;  // IDLE, B0..B(N-1)
`endif
    localparam int ST_W    = (N_STATES > 2) ? $clog2(N_STATES) : 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int PRIME_W = $clog2(PRIME_N + 2);

    localparam logic [ST_W-1:0]  ST_IDLE   = ST_W'(0);
    localparam logic [ST_W-1:0]  ST_B0     = ST_W'(1);
    localparam logic [ST_W-1:0]  ST_LAST   = ST_W'(N_STATES - 1);
    localparam logic [DIV_W-1:0] RATIO_MIN = DIV_W'(7);

`ifdef RDSEQ_CHKSUM_EN
    // XOR of all data bytes of one word
    function automatic logic [7:0] word_xor(input logic [DATA_W-1:0] w);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < N_BYTES; k++) begin
            acc = acc ^ w[8*k +: 8];
        end
        return acc;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    // divider
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   ratio_q, ratio_d;
    logic [DIV_W-1:0]   ratio_clamp_s;
    logic               strobe_q, strobe_d;
    logic               en_prev_q, en_prev_d;
    logic               rise_s;
    // capture
    logic [CAP_DLY-1:0] cap_sr_q, cap_sr_d;
    logic [PRIME_W-1:0] prime_q, prime_d;
    logic               capture_s;
    logic               push_s;
    // fifo
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic               full_s;
    logic               pop_s;
    logic               wr_en_s;
    logic               ovf_set_s;
    logic [DATA_W-1:0]  head_s;
    // serializer
    logic [ST_W-1:0]    state_q, state_d;
    logic               accept_s;
    logic [7:0]         data_byte_s;

    // ------------------------------------------------------------------
    // Divider: count 0..R while enabled, strobe on wrap, pick up a new R
    // at every wrap, while stopped and on the first enabled cycle.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        strobe_d  = 1'b0;
        en_prev_d = enable;
        rise_s    = enable & ~en_prev_q;
        if (dec_ratio < RATIO_MIN) begin
            ratio_clamp_s = RATIO_MIN;
        end else begin
            ratio_clamp_s = dec_ratio;
        end
        if (!enable) begin
            cnt_d   = '0;
            ratio_d = ratio_clamp_s;
        end else if (rise_s) begin
            cnt_d   = DIV_W'(1);
            ratio_d = ratio_clamp_s;
        end else if (cnt_q == ratio_q) begin
            cnt_d    = '0;
            ratio_d  = ratio_clamp_s;
            strobe_d = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Capture: delay the strobe by the CIC output latency, discard the
    // first PRIME_N captures after reset or an enable rise.
    // ------------------------------------------------------------------
    always_comb begin
        cap_sr_d    = cap_sr_q;
        cap_sr_d[0] = strobe_q;
        for (int i = 1; i < CAP_DLY; i++) begin
            cap_sr_d[i] = cap_sr_q[i-1];
        end
        capture_s = cap_sr_q[CAP_DLY-1];
        push_s    = capture_s & (prime_q == '0);
        if (rise_s) begin
            prime_d = PRIME_W'(PRIME_N);
        end else if (capture_s && (prime_q != '0)) begin
            prime_d = prime_q - PRIME_W'(1);
        end else begin
            prime_d = prime_q;
        end
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping: push on capture, pop on the accepted last byte;
    // a push into a full FIFO only succeeds when a pop frees a slot.
    // ------------------------------------------------------------------
    always_comb begin
        full_s    = (level_q == LVL_W'(DEPTH));
        pop_s     = accept_s & byte_last;
        wr_en_s   = push_s & (~full_s | pop_s);
        ovf_set_s = push_s & full_s & ~pop_s;
        head_s    = mem_q[rd_ptr_q];
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = level_q + LVL_W'(wr_en_s) - LVL_W'(pop_s);
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // ------------------------------------------------------------------
    // Serializer next state: start on any held or arriving word, advance
    // only on a handshake, chain straight into the next word when one remains.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((level_q != '0) || push_s) begin
                    state_d = ST_B0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAST: begin
                if (accept_s) begin
                    if ((level_q > LVL_W'(1)) || push_s) begin
                        state_d = ST_B0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_LAST;
                end
            end
            default: begin
                if (state_q > ST_LAST) begin
                    state_d = ST_IDLE;
                end else if (accept_s) begin
                    state_d = state_q + ST_W'(1);
                end else begin
                    state_d = state_q;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serializer outputs: decode the current state into the byte port.
    // ------------------------------------------------------------------
    always_comb begin
        data_byte_s = 8'h00;
        for (int k = 0; k < N_BYTES; k++) begin
            data_byte_s = (state_q == ST_W'(k + 1)) ? head_s[DATA_W-1-8*k -: 8] : data_byte_s;
        end
        if ((state_q != ST_IDLE) && (state_q <= ST_LAST)) begin
            byte_valid = 1'b1;
            byte_first = (state_q == ST_B0);
            byte_last  = (state_q == ST_LAST);
`ifdef RDSEQ_CHKSUM_EN
            if (state_q == ST_LAST) begin
                byte_out = word_xor(head_s);
            end else begin
                byte_out = data_byte_s;
            end
`else
            byte_out = data_byte_s;
`endif
        end else begin
            byte_valid = 1'b0;
            byte_first = 1'b0;
            byte_last  = 1'b0;
            byte_out   = 8'h00;
        end
        accept_s = byte_valid & byte_ready;
    end

    // ------------------------------------------------------------------
    // Control registers with synchronous reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            ratio_q   <= RATIO_MIN;
            strobe_q  <= 1'b0;
            en_prev_q <= 1'b0;
            cap_sr_q  <= '0;
            prime_q   <= PRIME_W'(PRIME_N);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            strobe_q  <= strobe_d;
            en_prev_q <= en_prev_d;
            cap_sr_q  <= cap_sr_d;
            prime_q   <= prime_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
        end
    end

    // FIFO storage; contents are don't-care while the level is zero.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign dec_strobe = strobe_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_cic_readout_sequencer.sv
// Bench for cic_readout_sequencer: random stimulus, word-level reference model
// and byte scoreboard.
`timescale 1ns/1ps
module tb_cic_readout_sequencer;

    localparam int DATA_W  = 24;
    localparam int DEPTH   = 4;
    localparam int DIV_W   = 8;
    localparam int CAP_DLY = 1;
    localparam int PRIME_N = 2;
    localparam int NB      = DATA_W / 8;
`ifdef RDSEQ_CHKSUM_EN
    localparam int NBO = NB + 1;
`else
    localparam int NBO = NB;
`endif

    typedef struct packed {
        logic [7:0] b;
        logic       f;
        logic       l;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic [DIV_W-1:0]       dec_ratio;
    logic                   dec_strobe;
    logic [DATA_W-1:0]      sample_in;
    logic [7:0]             byte_out;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   byte_first;
    logic                   byte_last;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic                   clr_ovf;

    always #5 clk = ~clk;

    cic_readout_sequencer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .CAP_DLY(CAP_DLY), .PRIME_N(PRIME_N)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .dec_ratio(dec_ratio),
        .dec_strobe(dec_strobe), .sample_in(sample_in), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_first(byte_first),
        .byte_last(byte_last), .fifo_level(fifo_level), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_words  = 0;
    bit   rand_sample = 1'b0;

    // reference model state
    int   m_level, m_pos, m_prime, sedge;
    bit   m_ovf, m_strobe, m_en_prev;
    int   capq[$];
    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp(input int r);
        return (r < 7) ? 7 : r;
    endfunction

    task automatic model_reset();
        m_level = 0; m_pos = 0; m_prime = PRIME_N; sedge = -1;
        m_ovf = 1'b0; m_strobe = 1'b0; m_en_prev = 1'b0;
        capq.delete();
        exp_q.delete();
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        exp_t e;
        logic [7:0] ck;
        ck = 8'h00;
        for (int k = 0; k < NB; k++) begin
            e.b = w[DATA_W-1-8*k -: 8];
            e.f = (k == 0);
            e.l = (k == NB - 1) && (NBO == NB);
            ck  = ck ^ e.b;
            exp_q.push_back(e);
        end
        if (NBO > NB) begin
            e.b = ck; e.f = 1'b0; e.l = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Reference model: per-cycle expectations, then the effect of the coming edge.
    initial begin : model
        bit pop, rise, ovf_set;
        model_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            chk("dec_strobe", dec_strobe, m_strobe);
            chk("byte_valid", byte_valid, m_level > 0);
            chk("fifo_level", fifo_level, m_level);
            chk("overflow", overflow, m_ovf);
            if (m_level == 0) chk("idle_byte_out", byte_out, 0);
            if (rst) begin
                model_reset();
            end else begin
                pop  = (m_level > 0) && byte_ready && (m_pos == NBO - 1);
                if ((m_level > 0) && byte_ready) m_pos = pop ? 0 : m_pos + 1;
                rise = enable && !m_en_prev;
                m_strobe = 1'b0;
                if (!enable) begin
                    sedge = -1;
                end else if (rise) begin
                    sedge = cyc + clamp(int'(dec_ratio));
                end else if (cyc == sedge) begin
                    m_strobe = 1'b1;
                    capq.push_back(cyc + 1 + CAP_DLY);
                    sedge = cyc + clamp(int'(dec_ratio)) + 1;
                end
                ovf_set = 1'b0;
                if (capq.size() > 0 && capq[0] == cyc) begin
                    void'(capq.pop_front());
                    if (m_prime > 0) begin
                        m_prime--;
                    end else if (m_level == DEPTH && !pop) begin
                        ovf_set = 1'b1;
                    end else begin
                        push_word(sample_in);
                        m_level++;
                    end
                end
                if (rise) m_prime = PRIME_N;
                if (pop) m_level--;
                m_ovf = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf);
                m_en_prev = enable;
            end
        end
    end

    // Monitor: every accepted byte must match the front of the scoreboard.
    initial begin : monitor
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst && byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL byte_unexpected: got 0x%0h, expected no byte (cycle %0d)", byte_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_out", byte_out, e.b);
                    chk("byte_first", byte_first, e.f);
                    chk("byte_last", byte_last, e.l);
                    if (byte_last) n_words++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_sample) sample_in = DATA_W'($urandom());
    endtask

    initial begin : driver
        int rdy_pct;
        rst = 1'b1; enable = 1'b0; dec_ratio = 8'd63; sample_in = '0;
        byte_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) tick();
        rst = 1'b0; byte_ready = 1'b1;

        // constant word, ratio 63: two primed captures discarded, then AB,CD,EF
        sample_in = 24'hABCDEF; enable = 1'b1; dec_ratio = 8'd63;
        repeat (64 * 4 + 10) tick();
        chk("phase1_words", n_words, 2);

        // clamped ratio, then a mid-period ratio change
        rand_sample = 1'b1;
        dec_ratio = 8'd2;
        repeat (60) tick();
        dec_ratio = 8'd63;
        repeat (100) tick();
        dec_ratio = 8'd15;
        repeat (80) tick();

        // consumer stalled: fill, overflow, clear
        dec_ratio = 8'd7; byte_ready = 1'b0;
        repeat (200) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        repeat (3) tick();
        byte_ready = 1'b1;
        repeat (100) tick();

        // random traffic
        for (int blk = 0; blk < 12; blk++) begin
            rdy_pct = $urandom_range(10, 90);
            for (int i = 0; i < 250; i++) begin
                tick();
                byte_ready = ($urandom_range(0, 99) < rdy_pct);
                clr_ovf    = ($urandom_range(0, 40) == 0);
                if (i % 60 == 0) dec_ratio = DIV_W'($urandom_range(0, 20));
            end
            if (blk % 4 == 3) begin
                enable = 1'b0;
                repeat ($urandom_range(4, 12)) tick();
                enable = 1'b1;
            end
        end
        clr_ovf = 1'b0;

        // reset while the second byte of a word is presented
        dec_ratio = 8'd7; byte_ready = 1'b0;
        repeat (60) tick();
        byte_ready = 1'b1;
        begin : wait_b1
            int i;
            for (i = 0; i < 500 && !(m_level > 0 && m_pos == 1); i++) tick();
            if (!(m_level > 0 && m_pos == 1)) begin
                n_checks++; n_fail++;
                $display("FAIL wait_byte2: timeout after %0d cycles", i);
            end
        end
        byte_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; byte_ready = 1'b1;
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_dec_strobe", dec_strobe, 0);
        chk("rst_overflow", overflow, 0);
        repeat (300) tick();

        // drain
        enable = 1'b0; byte_ready = 1'b1;
        begin : drain
            int i;
            for (i = 0; i < 400 && (m_level > 0 || exp_q.size() > 0); i++) tick();
            if (m_level > 0 || exp_q.size() > 0) begin
                n_checks++; n_fail++;
                $display("FAIL drain: %0d bytes still expected after %0d cycles", exp_q.size(), i);
            end
        end
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
